// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the accumulator receive path.
//   acc_state_e  : reader FSM states (PRIME, RUN)
//   ACC_WIDTH    : default data width of sums and increments
//   ACC_DEPTH    : default increment FIFO depth (power of two, >= 2)
package acc_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } acc_state_e;

  localparam int unsigned ACC_WIDTH = 5;
  localparam int unsigned ACC_DEPTH = 4;

endpackage

// File: rtl/acc_fifo.sv
// acc_fifo: synchronous FIFO with a registered head word.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   push_i, din_i : write request and data (dropped when full with no pop)
//   ready_i       : consumer accepts the head this cycle
//   dout_o        : registered head entry
//   dout_valid_o  : registered, FIFO non-empty
//   count_o       : registered occupancy
module acc_fifo
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_WIDTH,
  parameter int unsigned DEPTH = ACC_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             din_i,
  input  logic                         ready_i,
  output logic [WIDTH-1:0]             dout_o,
  output logic                         dout_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d, remain;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             pop, full, push_ok;

  always_comb begin
    pop     = valid_q && ready_i;
    full    = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees the slot the push needs.
    push_ok = push_i && (!full || pop);
    rd_d    = pop     ? rd_q + AW'(1) : rd_q;
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop);
    remain  = count_q - CW'(pop);
    // Head register tracks mem[rd_d]; when the FIFO would otherwise be
    // empty the incoming word lands in the head directly (one-cycle latency).
    head_d  = head_q;
    if (remain != '0) begin
      head_d = mem_q[rd_d];
    end else if (push_ok) begin
      head_d = din_i;
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  assign dout_o       = head_q;
  assign dout_valid_o = valid_q;
  assign count_o      = count_q;

endmodule

// File: rtl/acc_reader.sv
// acc_reader: recovers per-step increments from an accumulator's running sum
// (first difference mod 2^WIDTH) and queues them for a valid/ready consumer.
//   pclk, reset          : clock, asynchronous active-high reset
//   acc_out, acc_valid   : sampled running sum and its strobe
//   rearm                : re-prime request (also clears ovf)
//   dout, dout_valid,
//   dout_ready           : head-of-FIFO increment handshake
//   count                : FIFO occupancy
//   ovf                  : sticky dropped-push flag
// Build option: define ACC_READER_OVF_EN to enable ovf; otherwise ovf is 0.
module acc_reader
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_WIDTH,
  parameter int unsigned DEPTH = ACC_DEPTH
) (
  input  logic                         pclk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             acc_out,
  input  logic                         acc_valid,
  input  logic                         rearm,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  acc_state_e       state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] diff;
  logic             push;

  assign diff = acc_out - base_q;

  // Every sample reloads base; only a RUN-state sample without rearm pushes.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    push    = 1'b0;
    if (acc_valid) begin
      base_d  = acc_out;
      state_d = RUN;
      push    = (state_q == RUN) && !rearm;
    end else if (rearm) begin
      state_d = PRIME;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q <= PRIME;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  acc_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (pclk),
    .rst_i        (reset),
    .push_i       (push),
    .din_i        (diff),
    .ready_i      (dout_ready),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .count_o      (count)
  );

`ifdef ACC_READER_OVF_EN
  logic ovf_q, ovf_d, drop;

  assign drop = push && (count == CW'(DEPTH)) && !(dout_valid && dout_ready);

  always_comb begin
    ovf_d = rearm ? 1'b0 : (ovf_q | drop);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
